// File: rtl/mp_reg_file.sv
// Multi-port general register file with write-to-read bypass and a pending-write
// scoreboard used by issue logic to detect RAW hazards.
module mp_reg_file #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*DW-1:0] wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [AW:0]       busy_cnt,
  output logic              err_collide
);

  localparam int NREG = 2**AW;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [AW:0]     busyCnt;
  logic            errCollide;

  logic [NWR-1:0]  wrOk;
  logic [NWR-1:0]  wrDup;
  logic            collide;
  logic            issOk;
  logic            incOne;
  logic [AW:0]     decCnt;

  assign busy_cnt    = busyCnt;
  assign err_collide = errCollide;
  assign issOk       = iss_en && !(ZERO_REG != 0 && iss_addr == '0);

  // wrDup marks a port shadowed by a higher-index port writing the same register
  always_comb begin
    wrOk    = '0;
    wrDup   = '0;
    collide = 1'b0;
    for (int p = 0; p < NWR; p++)
      wrOk[p] = wr_en[p] && !(ZERO_REG != 0 && wr_addr[p*AW +: AW] == '0);
    for (int p = 0; p < NWR; p++)
      for (int q = p + 1; q < NWR; q++)
        if (wrOk[p] && wrOk[q] && wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW]) begin
          wrDup[p] = 1'b1;
          collide  = 1'b1;
        end
  end

  // Net count change: a commit only frees a register if it was busy and is not re-issued
  always_comb begin
    decCnt = '0;
    for (int p = 0; p < NWR; p++)
      if (wrOk[p] && !wrDup[p] && busy[wr_addr[p*AW +: AW]] &&
          !(issOk && iss_addr == wr_addr[p*AW +: AW]))
        decCnt = decCnt + (AW+1)'(1);
    incOne = issOk && !busy[iss_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (wrOk[p])
          regs[wr_addr[p*AW +: AW]] <= wr_data[p*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busyCnt    <= '0;
      errCollide <= 1'b0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (wrOk[p])
          busy[wr_addr[p*AW +: AW]] <= 1'b0;
      if (issOk)
        busy[iss_addr] <= 1'b1;
      busyCnt <= busyCnt + {{AW{1'b0}}, incOne} - decCnt;
      if (collide)
        errCollide <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : gRd
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          hitWr;
    logic          hitIss;

    assign addr = rd_addr[i*AW +: AW];

    always_comb begin
      data  = regs[addr];
      hitWr = 1'b0;
      if (BYPASS != 0)
        for (int p = 0; p < NWR; p++)
          if (wrOk[p] && wr_addr[p*AW +: AW] == addr) begin
            data  = wr_data[p*DW +: DW];
            hitWr = 1'b1;
          end
      if (ZERO_REG != 0 && addr == '0)
        data = '0;
    end

    assign hitIss             = issOk && iss_addr == addr;
    assign rd_data[i*DW +: DW] = data;
    assign rd_busy[i]         = busy[addr] && !(hitWr && !hitIss);
  end

endmodule

// File: tb/tb_mp_reg_file.sv
// Self-checking bench for mp_reg_file: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_mp_reg_file;
  localparam int DW = 32, AW = 5, NRD = 2, NWR = 2, NREG = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [AW:0]       busy_cnt;
  logic              err_collide;

  int errCnt = 0;
  int chkCnt = 0;

  logic [DW-1:0] mMem [NREG];
  bit            mBusy [NREG];
  bit            mErr;

  mp_reg_file #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .busy_cnt(busy_cnt), .err_collide(err_collide)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit wrLegal(int p);
    return wr_en[p] && wr_addr[p*AW +: AW] != 0;
  endfunction

  function automatic int modelCnt();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(mBusy[r]);
    return n;
  endfunction

  task automatic modelEdge();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin mMem[r] = '0; mBusy[r] = 0; end
      mErr = 0;
    end else begin
      for (int p = 0; p < NWR; p++)
        for (int q = p + 1; q < NWR; q++)
          if (wrLegal(p) && wrLegal(q) && wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW]) mErr = 1;
      for (int p = 0; p < NWR; p++)
        if (wrLegal(p)) begin
          mMem[wr_addr[p*AW +: AW]]  = wr_data[p*DW +: DW];
          mBusy[wr_addr[p*AW +: AW]] = 0;
        end
      if (iss_en && iss_addr != 0) mBusy[iss_addr] = 1;
    end
  endtask

  task automatic checkReads(input string tag);
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] expD;
      bit wrHit, issHit, expB;
      a = rd_addr[i*AW +: AW];
      expD = mMem[a];
      wrHit = 0;
      for (int p = 0; p < NWR; p++)
        if (wrLegal(p) && wr_addr[p*AW +: AW] == a) begin expD = wr_data[p*DW +: DW]; wrHit = 1; end
      if (a == 0) expD = '0;
      issHit = iss_en && iss_addr == a && a != 0;
      expB = mBusy[a] && !(wrHit && !issHit);
      checkVal($sformatf("%s rd_data[%0d]", tag, i), 64'(rd_data[i*DW +: DW]), 64'(expD));
      checkVal($sformatf("%s rd_busy[%0d]", tag, i), 64'(rd_busy[i]), 64'(expB));
    end
  endtask

  // Inputs are held; reads checked mid-cycle, then the edge is taken and state checked.
  task automatic cycle(input string tag);
    #2;
    if (!rst) checkReads(tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkVal({tag, " busy_cnt"}, 64'(busy_cnt), 64'(modelCnt()));
    checkVal({tag, " err_collide"}, 64'(err_collide), 64'(mErr));
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = '0; iss_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    mErr = 0;
    for (int r = 0; r < NREG; r++) begin mMem[r] = $urandom; mBusy[r] = 1; end
    @(negedge clk);

    // 1: reset, then every register reads 0 and idle
    cycle("t1 rst");
    idle();
    for (int a = 0; a < NREG; a++) begin
      rd_addr[0 +: AW] = AW'(a);
      rd_addr[AW +: AW] = AW'(NREG - 1 - a);
      #1;
      checkVal("t1 rd_data0", 64'(rd_data[0 +: DW]), 64'h0);
      checkVal("t1 rd_data1", 64'(rd_data[DW +: DW]), 64'h0);
      checkVal("t1 rd_busy", 64'(rd_busy), 64'h0);
    end
    checkVal("t1 busy_cnt", 64'(busy_cnt), 64'h0);
    checkVal("t1 err_collide", 64'(err_collide), 64'h0);

    // 2: bypass then stored value
    wr_en = 2'b01; wr_addr[0 +: AW] = 5; wr_data[0 +: DW] = 32'hDEADBEEF;
    rd_addr[0 +: AW] = 5; rd_addr[AW +: AW] = 5;
    #1 checkVal("t2 bypass", 64'(rd_data[0 +: DW]), 64'hDEADBEEF);
    cycle("t2 wr");
    idle();
    #1 checkVal("t2 stored", 64'(rd_data[DW +: DW]), 64'hDEADBEEF);
    cycle("t2 idle");

    // 3: register 0 is never written nor busy
    wr_en = 2'b01; wr_addr[0 +: AW] = 0; wr_data[0 +: DW] = 32'h1234;
    iss_en = 1'b1; iss_addr = 0; rd_addr[0 +: AW] = 0;
    #1 checkVal("t3 r0 data", 64'(rd_data[0 +: DW]), 64'h0);
    checkVal("t3 r0 busy", 64'(rd_busy[0]), 64'h0);
    cycle("t3");
    idle();
    checkVal("t3 busy_cnt", 64'(busy_cnt), 64'h0);

    // 4: collision, higher port wins
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr[0 +: AW] = 7;
    #1 checkVal("t4 bypass", 64'(rd_data[0 +: DW]), 64'h22);
    cycle("t4 wr");
    idle();
    #1 checkVal("t4 stored", 64'(rd_data[0 +: DW]), 64'h22);
    checkVal("t4 err", 64'(err_collide), 64'h1);
    cycle("t4 idle");
    checkVal("t4 err sticky", 64'(err_collide), 64'h1);

    // 5: scoreboard set/clear on r3
    rd_addr[0 +: AW] = 3; iss_en = 1'b1; iss_addr = 3;
    cycle("t5 iss");
    checkVal("t5 cnt1", 64'(busy_cnt), 64'h1);
    wr_en = 2'b01; wr_addr[0 +: AW] = 3; wr_data[0 +: DW] = 32'h55;
    #1 checkVal("t5 busy wr+iss", 64'(rd_busy[0]), 64'h1);
    cycle("t5 wr+iss");
    checkVal("t5 cnt still 1", 64'(busy_cnt), 64'h1);
    iss_en = 1'b0; wr_data[0 +: DW] = 32'h66;
    #1 checkVal("t5 busy masked", 64'(rd_busy[0]), 64'h0);
    cycle("t5 wr");
    idle();
    checkVal("t5 cnt0", 64'(busy_cnt), 64'h0);
    #1 checkVal("t5 r3", 64'(rd_data[0 +: DW]), 64'h66);

    // 6: reset in the middle of outstanding work
    iss_en = 1'b1; iss_addr = 1; cycle("t6 iss1");
    iss_addr = 2; cycle("t6 iss2");
    iss_addr = 4; cycle("t6 iss4");
    checkVal("t6 cnt3", 64'(busy_cnt), 64'h3);
    idle();
    rst = 1'b1; wr_en = 2'b01; wr_addr[0 +: AW] = 2; wr_data[0 +: DW] = 32'h99;
    cycle("t6 rst");
    idle();
    rd_addr[0 +: AW] = 2; rd_addr[AW +: AW] = 5;
    #1 checkVal("t6 r2", 64'(rd_data[0 +: DW]), 64'h0);
    checkVal("t6 r5", 64'(rd_data[DW +: DW]), 64'h0);
    checkVal("t6 cnt", 64'(busy_cnt), 64'h0);
    checkVal("t6 err", 64'(err_collide), 64'h0);

    // randomized traffic on a narrow address window to provoke hazards and collisions
    for (int n = 0; n < 600; n++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? NREG - 1 : 7;
      rst = ($urandom_range(0, 79) == 0);
      for (int p = 0; p < NWR; p++) begin
        wr_en[p] = ($urandom_range(0, 2) != 0);
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, hi));
        wr_data[p*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 15) == 0) wr_en = '0;
      iss_en = ($urandom_range(0, 1) == 1);
      iss_addr = AW'($urandom_range(0, hi));
      for (int i = 0; i < NRD; i++)
        rd_addr[i*AW +: AW] = ($urandom_range(0, 2) == 0) ? wr_addr[0 +: AW] : AW'($urandom_range(0, hi));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
